program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Upstream feeder of the CPU instruction memory. Receives a byte stream over a valid/ready
//  handshake, assembles 16-bit instructions, and writes them into instruction memory.
//  Holds the CPU in reset during loading. Verifies an XOR checksum, then releases the CPU.
//  Top level muxes o_addr onto the instruction-memory address while o_cpu_rst is high.
// PARAMETERS
//  ADDR_WIDTH  8  instruction-memory address width; legal range 1..8
// PORTS
//  i_clk      in   1           clock; all state changes on rising edge
//  i_rst      in   1           asynchronous, active-high reset
//  i_start    in   1           begin a new load; sampled only in IDLE, RUN or ERR
//  i_byte     in   8           stream data byte
//  i_valid    in   1           i_byte valid
//  o_ready    out  1           loader accepts a byte; transfer = i_valid & o_ready at edge
//  o_addr     out  ADDR_WIDTH  instruction-memory write address
//  o_instr    out  16          instruction-memory write data
//  o_we       out  1           instruction-memory write enable, one-cycle pulse per word
//  o_cpu_rst  out  1           CPU reset; high except in RUN
//  o_done     out  1           load completed, checksum good, CPU running
//  o_err      out  1           checksum mismatch; CPU held in reset
// BEHAVIOUR
//  Reset values: state=IDLE, o_addr=0, o_instr=0, o_we=0, o_cpu_rst=1, o_done=0, o_err=0,
//   o_ready=0. Internal count/checksum registers reset to 0.
//  Stream format: COUNT byte N, then N words (high byte first, then low byte), then CSUM byte.
//   N=0 means 256 words.
//  o_ready=1 only in COUNT, HI, LO and CSUM. A stall on i_valid holds the state indefinitely.
//  States and transitions:
//   IDLE : i_start -> COUNT; clears o_addr, checksum, o_done, o_err.
//   COUNT: byte accepted -> remaining=N (0 -> 256); csum=byte; go to HI.
//   HI   : byte accepted -> o_instr[15:8]=byte; csum^=byte; go to LO.
//   LO   : byte accepted -> o_instr[7:0]=byte; csum^=byte; go to WRITE.
//   WRITE: o_we=1 for exactly this cycle, using the current o_addr and o_instr.
//          Then o_addr+=1 (wraps modulo 2^ADDR_WIDTH); remaining-=1.
//          Next state is CSUM if remaining becomes 0, otherwise HI.
//   CSUM : byte accepted -> byte==csum ? RUN : ERR.
//   RUN  : o_cpu_rst=0, o_done=1. i_start -> COUNT; o_cpu_rst is high again from that next cycle.
//   ERR  : o_err=1, o_cpu_rst=1. i_start -> COUNT.
//  Exactly one write per word. Latency from the accepted low byte to o_we is 1 cycle.
//  The first RUN cycle (o_cpu_rst low) follows the edge that accepted a good CSUM.
//  i_start is ignored in COUNT, HI, LO, WRITE and CSUM.
//  A byte offered while o_ready=0 is not consumed.
//  If N exceeds 2^ADDR_WIDTH, the address wraps and later words overwrite earlier ones.
//   This is not an error.
//  i_rst mid-load: all registers return immediately to reset values (async) and the load is
//   aborted. Words already written stay in memory; a new i_start is required.
// TESTING
//  1 Good load: start; 02,12,34,AB,CD,42 -> we@addr0=1234, we@addr1=ABCD; done=1, cpu_rst=0.
//  2 Bad checksum: same stream with CSUM=43 -> two writes occur; then err=1, done=0, cpu_rst=1.
//  3 Backpressure: deassert i_valid randomly between bytes -> identical writes/order as test 1;
//     no byte lost or duplicated; ready=0 during WRITE.
//  4 Max count: N=00, 256 words of value k -> 256 we pulses, addr 00..FF;
//     o_addr ends at 00; correct CSUM -> RUN.
//  5 Async reset after the first word's HI byte -> outputs at reset values before next edge;
//     fresh start + test-1 stream succeeds.
//  6 Restart from RUN and from ERR via i_start -> cpu_rst rises next cycle; done/err clear;
//     o_addr restarts at 0.

Source files
------------

// File: rtl/program_loader.sv
// Byte-stream program loader: assembles 16-bit words from a valid/ready byte stream,
// writes them to instruction memory, checks an XOR checksum and releases the CPU.
module program_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [7:0]            i_byte,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [15:0]           o_instr,
  output logic                  o_we,
  output logic                  o_cpu_rst,
  output logic                  o_done,
  output logic                  o_err
);

  // state  | meaning
  // IDLE   | waiting for first i_start after reset
  // COUNT  | accepting word-count byte (0 means 256)
  // HI     | accepting high byte of next word
  // LO     | accepting low byte of next word
  // WRITE  | one-cycle write pulse, then advance address
  // CSUM   | accepting checksum byte
  // RUN    | checksum good, CPU released
  // ERR    | checksum bad, CPU held in reset
  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_CSUM, S_RUN, S_ERR
  } state_t;

  state_t                r_state;
  logic [8:0]            r_remaining;
  logic [7:0]            r_csum;
  logic                  r_ready;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_instr;
  logic                  r_we;
  logic                  r_cpu_rst;
  logic                  r_done;
  logic                  r_err;
  logic                  w_xfer;

  assign w_xfer = i_valid & r_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_csum      <= '0;
      r_ready     <= 1'b0;
      r_addr      <= '0;
      r_instr     <= '0;
      r_we        <= 1'b0;
      r_cpu_rst   <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_RUN, S_ERR: begin
          if (i_start) begin
            r_state   <= S_COUNT;
            r_addr    <= '0;
            r_csum    <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cpu_rst <= 1'b1;
            r_ready   <= 1'b1;
          end
        end
        S_COUNT: begin
          if (w_xfer) begin
            r_remaining <= (i_byte == 8'd0) ? 9'd256 : {1'b0, i_byte};
            r_csum      <= i_byte;
            r_state     <= S_HI;
          end
        end
        S_HI: begin
          if (w_xfer) begin
            r_instr[15:8] <= i_byte;
            r_csum        <= r_csum ^ i_byte;
            r_state       <= S_LO;
          end
        end
        S_LO: begin
          if (w_xfer) begin
            r_instr[7:0] <= i_byte;
            r_csum       <= r_csum ^ i_byte;
            r_state      <= S_WRITE;
            r_we         <= 1'b1;
            r_ready      <= 1'b0;
          end
        end
        S_WRITE: begin
          // address wraps naturally; overflowing counts overwrite earlier words
          r_addr      <= r_addr + 1'b1;
          r_remaining <= r_remaining - 9'd1;
          r_state     <= (r_remaining == 9'd1) ? S_CSUM : S_HI;
          r_ready     <= 1'b1;
        end
        S_CSUM: begin
          if (w_xfer) begin
            r_ready <= 1'b0;
            if (i_byte == r_csum) begin
              r_state   <= S_RUN;
              r_cpu_rst <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready   = r_ready;
  assign o_addr    = r_addr;
  assign o_instr   = r_instr;
  assign o_we      = r_we;
  assign o_cpu_rst = r_cpu_rst;
  assign o_done    = r_done;
  assign o_err     = r_err;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: directed and randomized loads checked against
// a queue-based stream/write model built in the bench.
module tb_program_loader;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    byte_in;
  logic          valid;
  logic          ready;
  logic [AW-1:0] addr;
  logic [15:0]   instr;
  logic          we;
  logic          cpu_rst;
  logic          done;
  logic          err;

  int errors = 0;
  int checks = 0;

  logic [15:0]        words[$];
  logic [AW+15:0]     obs[$];

  program_loader #(.ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_byte(byte_in), .i_valid(valid),
    .o_ready(ready), .o_addr(addr), .o_instr(instr), .o_we(we),
    .o_cpu_rst(cpu_rst), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // write monitor: every pulse is captured, and the loader must not accept bytes meanwhile
  always @(negedge clk) begin
    if (!rst && we) begin
      obs.push_back({addr, instr});
      checks++;
      assert (ready === 1'b0) else begin
        errors++;
        $error("FAIL ready_in_write: observed=%0b expected=0", ready);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bp);
    int bound;
    if (bp) begin
      valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    valid   = 1'b1;
    byte_in = b;
    bound   = 0;
    while (ready !== 1'b1 && bound < 50) begin
      @(negedge clk);
      bound++;
    end
    if (bound >= 50) chk("ready_timeout", 32'(ready), 32'd1);
    @(negedge clk);
    valid   = 1'b0;
    byte_in = $urandom_range(0, 255);
  endtask

  task automatic do_start(input bit hold);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk("start_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_err", 32'(err), 32'd0);
    chk("start_addr", 32'(addr), 32'd0);
    chk("start_ready", 32'(ready), 32'd1);
  endtask

  // n: word count 1..256; words[] holds the data. The model expects write k at
  // address k mod 2^AW and a checksum equal to the XOR of every preceding byte.
  task automatic run_load(input int n, input bit bad, input bit bp, input bit hold);
    logic [7:0] stream[$];
    logic [7:0] cs;
    int         nw;
    obs.delete();
    stream.delete();
    cs = 8'(n);
    stream.push_back(8'(n));
    for (int k = 0; k < n; k++) begin
      stream.push_back(words[k][15:8]);
      stream.push_back(words[k][7:0]);
      cs = cs ^ words[k][15:8] ^ words[k][7:0];
    end
    stream.push_back(bad ? (cs ^ 8'h01) : cs);
    do_start(hold);
    for (int i = 0; i < stream.size(); i++) begin
      if (i == stream.size() - 1) start = 1'b0;
      send_byte(stream[i], bp);
    end
    chk("end_done", 32'(done), bad ? 32'd0 : 32'd1);
    chk("end_err", 32'(err), bad ? 32'd1 : 32'd0);
    chk("end_cpu_rst", 32'(cpu_rst), bad ? 32'd1 : 32'd0);
    chk("end_ready", 32'(ready), 32'd0);
    chk("end_addr", 32'(addr), 32'(n % (1 << AW)));
    chk("write_count", 32'(obs.size()), 32'(n));
    nw = (obs.size() < n) ? obs.size() : n;
    for (int k = 0; k < nw; k++)
      chk($sformatf("write%0d", k), 32'(obs[k]), 32'({AW'(k), words[k]}));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; byte_in = 8'h00;
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // bytes offered in IDLE must not be consumed
    valid = 1'b1; byte_in = 8'h55;
    repeat (3) @(negedge clk);
    chk("idle_ready", 32'(ready), 32'd0);
    valid = 1'b0;

    words = '{16'h1234, 16'hABCD};
    run_load(2, 1'b0, 1'b0, 1'b0);
    run_load(2, 1'b1, 1'b0, 1'b0);
    run_load(2, 1'b0, 1'b1, 1'b1);

    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, 40);
      words.delete();
      for (int k = 0; k < n; k++) words.push_back(16'($urandom));
      run_load(n, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
    end

    words.delete();
    for (int k = 0; k < 256; k++) words.push_back({8'(k), ~8'(k)});
    run_load(256, 1'b0, 1'b0, 1'b0);

    // async reset in the middle of the first word
    words = '{16'h1234, 16'hABCD};
    do_start(1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_instr", 32'(instr), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("mid_rst_addr", 32'(addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready), 32'd0);
    run_load(2, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
